// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with request/grant/ack handshake.
// Emits a registered binary grant index and valid flag for the downstream 3-to-8 decoder.
module rr_arbiter8 #(
  parameter int NREQ = 8,
  parameter int IDXW = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            ack,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic [CNTW-1:0] grant_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [CNTW-1:0]   count_q, count_d;

  // First asserted request at or after the pointer, wrapping modulo NREQ.
  function automatic logic [IDXW-1:0] pick_next(input logic [NREQ-1:0] r,
                                                input logic [IDXW-1:0] p);
    logic [IDXW-1:0] cand;
    logic            found;
    pick_next = p;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = p + IDXW'(i);
      if (!found && r[cand]) begin
        pick_next = cand;
        found     = 1'b1;
      end else begin
        found     = found;
      end
    end
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    sat_inc = (c == {CNTW{1'b1}}) ? c : c + CNTW'(1);
  endfunction

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (|req) begin
          idx_d   = pick_next(req, ptr_q);
          valid_d = 1'b1;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Ack wins over a simultaneous withdrawal so the transfer is counted.
        if (ack) begin
          ptr_d   = idx_q + IDXW'(1);
          count_d = sat_inc(count_q);
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (!req[idx_q]) begin
          ptr_d   = idx_q + IDXW'(1);
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign grant_count = count_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: each step queues the expected
// {valid, idx, count} and compares it one clock later.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       ack;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic [7:0] grant_count;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  rr_arbiter8 dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] r, input logic a, input logic s,
                      input logic ev, input logic [2:0] ei, input logic [7:0] ec,
                      input string tag);
    logic [11:0] got;
    logic [11:0] exp;
    req = r;
    ack = a;
    rst = s;
    exp_q.push_back({ev, ei, ec});
    @(posedge clk);
    #1;
    got = {grant_valid, grant_idx, grant_count};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s got v=%b idx=%0d cnt=%0d exp v=%b idx=%0d cnt=%0d",
               tag, got[11], got[10:8], got[7:0], exp[11], exp[10:8], exp[7:0]);
      end
    end
  endtask

  function automatic logic [7:0] sat(input int c);
    sat = (c > 255) ? 8'd255 : c[7:0];
  endfunction

  initial begin
    int cnt;
    logic [2:0] g;
    rst = 1'b1;
    req = 8'h00;
    ack = 1'b0;

    step(8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, "reset0");
    step(8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, "reset1");
    step(8'hFF, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0, "first_grant");
    cnt = 1;
    step(8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, sat(cnt), "first_ack");

    // All requesting: 1..7 then wrap to 0
    for (int k = 1; k <= 8; k++) begin
      g = 3'(k % 8);
      step(8'hFF, 1'b0, 1'b0, 1'b1, g, sat(cnt), "ff_grant");
      cnt++;
      step(8'hFF, 1'b1, 1'b0, 1'b0, g, sat(cnt), "ff_ack");
    end

    // Two requesters at opposite ends alternate (ptr=1 here, so 7 first)
    for (int j = 0; j < 4; j++) begin
      g = (j % 2 == 0) ? 3'd7 : 3'd0;
      step(8'h81, 1'b0, 1'b0, 1'b1, g, sat(cnt), "alt_grant");
      cnt++;
      step(8'h81, 1'b1, 1'b0, 1'b0, g, sat(cnt), "alt_ack");
    end

    // Withdrawal leaves count alone; ptr=4 then wraps to channel 0
    step(8'h08, 1'b0, 1'b0, 1'b1, 3'd3, sat(cnt), "wd_grant");
    step(8'h00, 1'b0, 1'b0, 1'b0, 3'd3, sat(cnt), "wd_drop");
    step(8'h09, 1'b0, 1'b0, 1'b1, 3'd0, sat(cnt), "wd_wrap");
    cnt++;
    step(8'h09, 1'b1, 1'b0, 1'b0, 3'd0, sat(cnt), "wd_ack");
    step(8'h00, 1'b1, 1'b0, 1'b0, 3'd0, sat(cnt), "idle_ack");

    // Hold grant on 2 while another request bit toggles
    step(8'h14, 1'b0, 1'b0, 1'b1, 3'd2, sat(cnt), "hold_grant");
    for (int t = 0; t < 5; t++) begin
      step((t % 2 == 0) ? 8'h04 : 8'h14, 1'b0, 1'b0, 1'b1, 3'd2, sat(cnt), "hold");
    end
    step(8'h14, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, "rst_mid_grant");
    cnt = 0;
    step(8'h14, 1'b0, 1'b0, 1'b1, 3'd2, 8'd0, "post_rst_grant");
    cnt++;
    step(8'h14, 1'b1, 1'b0, 1'b0, 3'd2, sat(cnt), "post_rst_ack");
    // ptr is now 3; reset must bring it back to 0 so channel 2 beats 4
    step(8'h14, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, "rst_idle");
    cnt = 0;
    step(8'h14, 1'b0, 1'b0, 1'b1, 3'd2, 8'd0, "ptr_reset");
    cnt++;
    step(8'h14, 1'b1, 1'b0, 1'b0, 3'd2, sat(cnt), "ptr_reset_ack");

    // Saturation of the completion counter
    for (int n = 0; n < 256; n++) begin
      step(8'h01, 1'b0, 1'b0, 1'b1, 3'd0, sat(cnt), "sat_grant");
      cnt++;
      step(8'h01, 1'b1, 1'b0, 1'b0, 3'd0, sat(cnt), "sat_ack");
    end
    step(8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'd255, "sat_idle_ack0");
    step(8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'd255, "sat_idle_ack1");
    step(8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'd255, "sat_regrant");
    step(8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 8'd255, "sat_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
